// File: rtl/fitness_scan.sv
// Sweeps the population register file once per new_data pulse and reports the
// maximum word, its index and the sum. FITNESS_SCAN_MIN_EN adds worst_val/worst_idx.
module fitness_scan #(
    parameter int POPSIZE    = 100,
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(POPSIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       new_data,
    input  logic                       data_vld,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       rd_rqst,
    output logic [$clog2(POPSIZE)-1:0] read_addr,
    output logic                       busy,
    output logic                       scan_done,
    output logic [DATA_WIDTH-1:0]      best_val,
    output logic [$clog2(POPSIZE)-1:0] best_idx,
    output logic [SUM_WIDTH-1:0]       fit_sum
`ifdef FITNESS_SCAN_MIN_EN
    ,
    output logic [DATA_WIDTH-1:0]      worst_val,
    output logic [$clog2(POPSIZE)-1:0] worst_idx
`endif
);
    localparam int AW = $clog2(POPSIZE);
    localparam logic [AW-1:0] LAST = AW'(POPSIZE - 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] scr_best;
    logic [AW-1:0]         scr_idx;
    logic [SUM_WIDTH-1:0]  scr_sum;
    logic                  take_best;

    // Member 0 seeds the scratch max; later members replace it only when strictly larger.
    assign take_best = (read_addr == '0) || (data_in > scr_best);

`ifdef FITNESS_SCAN_MIN_EN
    logic [DATA_WIDTH-1:0] scr_worst;
    logic [AW-1:0]         scr_widx;
    logic                  take_worst;
    assign take_worst = (read_addr == '0) || (data_in < scr_worst);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_rqst   <= 1'b0;
            read_addr <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            best_val  <= '0;
            best_idx  <= '0;
            fit_sum   <= '0;
            scr_best  <= '0;
            scr_idx   <= '0;
            scr_sum   <= '0;
`ifdef FITNESS_SCAN_MIN_EN
            worst_val <= '0;
            worst_idx <= '0;
            scr_worst <= '0;
            scr_widx  <= '0;
`endif
        end else begin
            scan_done <= 1'b0;
            // DONE commits even when a new frame arrives in the same cycle.
            if (state == DONE) begin
                best_val  <= scr_best;
                best_idx  <= scr_idx;
                fit_sum   <= scr_sum;
                scan_done <= 1'b1;
`ifdef FITNESS_SCAN_MIN_EN
                worst_val <= scr_worst;
                worst_idx <= scr_widx;
`endif
            end
            if (new_data) begin
                // A fresh frame always (re)starts the sweep; any in-flight word is dropped.
                state     <= REQ;
                rd_rqst   <= 1'b1;
                busy      <= 1'b1;
                read_addr <= '0;
                scr_best  <= '0;
                scr_idx   <= '0;
                scr_sum   <= '0;
`ifdef FITNESS_SCAN_MIN_EN
                scr_worst <= '0;
                scr_widx  <= '0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    REQ: begin
                        if (data_vld) begin
                            scr_sum <= scr_sum + SUM_WIDTH'(data_in);
                            if (take_best) begin
                                scr_best <= data_in;
                                scr_idx  <= read_addr;
                            end
`ifdef FITNESS_SCAN_MIN_EN
                            if (take_worst) begin
                                scr_worst <= data_in;
                                scr_widx  <= read_addr;
                            end
`endif
                            rd_rqst <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                    // One dead cycle swallows the repeated strobe the reg file may send.
                    DRAIN: begin
                        if (read_addr == LAST) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            read_addr <= read_addr + 1'b1;
                            rd_rqst   <= 1'b1;
                            state     <= REQ;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
